// File: rtl/dport_arbiter.sv
// Two-requester round-robin arbiter for the shared debug-port channel.
// Holds the grant from request through response and guards the channel with a watchdog.
module dport_arbiter #(
    parameter int unsigned RISCV_ARCH = 64,
    parameter int unsigned TYPE_W     = 5,
    parameter int unsigned TIMEOUT    = 4096,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_m0_req_valid,
    input  logic [TYPE_W-1:0]     i_m0_type,
    input  logic [RISCV_ARCH-1:0] i_m0_addr,
    input  logic [RISCV_ARCH-1:0] i_m0_wdata,
    input  logic [2:0]            i_m0_size,
    output logic                  o_m0_req_ready,
    input  logic                  i_m0_resp_ready,
    output logic                  o_m0_resp_valid,
    output logic                  o_m0_resp_error,
    output logic [RISCV_ARCH-1:0] o_m0_rdata,
    input  logic                  i_m1_req_valid,
    input  logic [TYPE_W-1:0]     i_m1_type,
    input  logic [RISCV_ARCH-1:0] i_m1_addr,
    input  logic [RISCV_ARCH-1:0] i_m1_wdata,
    input  logic [2:0]            i_m1_size,
    output logic                  o_m1_req_ready,
    input  logic                  i_m1_resp_ready,
    output logic                  o_m1_resp_valid,
    output logic                  o_m1_resp_error,
    output logic [RISCV_ARCH-1:0] o_m1_rdata,
    output logic                  o_dport_req_valid,
    output logic [TYPE_W-1:0]     o_dport_type,
    output logic [RISCV_ARCH-1:0] o_dport_addr,
    output logic [RISCV_ARCH-1:0] o_dport_wdata,
    output logic [2:0]            o_dport_size,
    input  logic                  i_dport_req_ready,
    input  logic                  i_dport_resp_valid,
    input  logic                  i_dport_resp_error,
    input  logic [RISCV_ARCH-1:0] i_dport_rdata,
    output logic                  o_dport_resp_ready,
    output logic                  o_owner,
    output logic                  o_busy,
    output logic                  o_timeout
);

    typedef enum logic [2:0] {IDLE, REQ, RESP, TOUT_RESP, DRAIN} state_t;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_t                  state, state_next;
    logic                    ptr, ptr_next;
    logic                    owner, owner_next;
    logic                    drain, drain_next;
    logic [CNT_W-1:0]        cnt, cnt_next, cnt_inc;
    logic [TYPE_W-1:0]       lat_type;
    logic [RISCV_ARCH-1:0]   lat_addr, lat_wdata;
    logic [2:0]              lat_size;
    logic                    any_req, winner, owner_resp_ready, resp_hs, at_limit, load;
    logic                    resp_valid, resp_error;
    logic [RISCV_ARCH-1:0]   resp_data;

    assign any_req          = i_m0_req_valid | i_m1_req_valid;
    assign winner           = (i_m0_req_valid & i_m1_req_valid) ? ptr : i_m1_req_valid;
    assign owner_resp_ready = owner ? i_m1_resp_ready : i_m0_resp_ready;
    assign resp_hs          = i_dport_resp_valid & owner_resp_ready;
    assign at_limit         = (TIMEOUT != 0) && (cnt == LIMIT);
    assign load             = (state == IDLE) && any_req;
    // Saturating; inert when the watchdog is disabled.
    assign cnt_inc          = ((TIMEOUT != 0) && (cnt != '1)) ? cnt + CNT_W'(1) : cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            ptr       <= 1'b0;
            owner     <= 1'b0;
            drain     <= 1'b0;
            cnt       <= '0;
            lat_type  <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_size  <= '0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
            owner <= owner_next;
            drain <= drain_next;
            cnt   <= cnt_next;
            if (load) begin
                lat_type  <= winner ? i_m1_type  : i_m0_type;
                lat_addr  <= winner ? i_m1_addr  : i_m0_addr;
                lat_wdata <= winner ? i_m1_wdata : i_m0_wdata;
                lat_size  <= winner ? i_m1_size  : i_m0_size;
            end
        end
    end

    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        owner_next = owner;
        drain_next = drain;
        cnt_next   = cnt;
        unique case (state)
            IDLE: begin
                if (any_req) begin
                    owner_next = winner;
                    cnt_next   = '0;
                    state_next = REQ;
                end
            end
            REQ: begin
                cnt_next = cnt_inc;
                if (i_dport_req_ready) begin
                    state_next = RESP;
                end else if (at_limit) begin
                    drain_next = 1'b0;
                    state_next = TOUT_RESP;
                end
            end
            RESP: begin
                cnt_next = cnt_inc;
                if (resp_hs) begin
                    ptr_next   = ~owner;
                    state_next = IDLE;
                end else if (at_limit) begin
                    drain_next = 1'b1;
                    state_next = TOUT_RESP;
                end
            end
            TOUT_RESP: begin
                if (drain && i_dport_resp_valid) drain_next = 1'b0;
                if (owner_resp_ready) begin
                    ptr_next   = ~owner;
                    state_next = drain_next ? DRAIN : IDLE;
                end
            end
            DRAIN: begin
                if (i_dport_resp_valid) begin
                    drain_next = 1'b0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        o_m0_req_ready     = 1'b0;
        o_m1_req_ready     = 1'b0;
        o_dport_req_valid  = 1'b0;
        o_dport_resp_ready = 1'b0;
        o_timeout          = 1'b0;
        resp_valid         = 1'b0;
        resp_error         = 1'b0;
        resp_data          = '0;
        if (!i_rst) begin
            unique case (state)
                IDLE: begin
                    o_m0_req_ready = any_req & ~winner;
                    o_m1_req_ready = any_req & winner;
                end
                REQ: begin
                    o_dport_req_valid = 1'b1;
                    o_timeout         = at_limit & ~i_dport_req_ready;
                end
                RESP: begin
                    resp_valid         = i_dport_resp_valid;
                    resp_error         = i_dport_resp_error;
                    resp_data          = i_dport_rdata;
                    o_dport_resp_ready = owner_resp_ready;
                    o_timeout          = at_limit & ~resp_hs;
                end
                TOUT_RESP: begin
                    resp_valid         = 1'b1;
                    resp_error         = 1'b1;
                    resp_data          = '1;
                    o_dport_resp_ready = drain;
                end
                DRAIN: o_dport_resp_ready = 1'b1;
                default: ;
            endcase
        end
        o_m0_resp_valid = resp_valid & ~owner;
        o_m0_resp_error = resp_error & ~owner;
        o_m0_rdata      = owner ? '0 : resp_data;
        o_m1_resp_valid = resp_valid & owner;
        o_m1_resp_error = resp_error & owner;
        o_m1_rdata      = owner ? resp_data : '0;
        o_dport_type    = i_rst ? '0 : lat_type;
        o_dport_addr    = i_rst ? '0 : lat_addr;
        o_dport_wdata   = i_rst ? '0 : lat_wdata;
        o_dport_size    = i_rst ? '0 : lat_size;
        o_owner         = ~i_rst & owner;
        o_busy          = ~i_rst & (state != IDLE);
    end

endmodule

// File: tb/tb_dport_arbiter.sv
// Directed bench for dport_arbiter with TIMEOUT=8: single read, contention,
// backpressure, request/response watchdog and mid-transaction reset.
module tb_dport_arbiter;

    localparam int unsigned W = 64;
    localparam int unsigned TW = 5;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_m0_req_valid, i_m1_req_valid;
    logic [TW-1:0] i_m0_type, i_m1_type;
    logic [W-1:0]  i_m0_addr, i_m1_addr, i_m0_wdata, i_m1_wdata;
    logic [2:0]    i_m0_size, i_m1_size;
    logic          o_m0_req_ready, o_m1_req_ready;
    logic          i_m0_resp_ready, i_m1_resp_ready;
    logic          o_m0_resp_valid, o_m1_resp_valid;
    logic          o_m0_resp_error, o_m1_resp_error;
    logic [W-1:0]  o_m0_rdata, o_m1_rdata;
    logic          o_dport_req_valid;
    logic [TW-1:0] o_dport_type;
    logic [W-1:0]  o_dport_addr, o_dport_wdata;
    logic [2:0]    o_dport_size;
    logic          i_dport_req_ready, i_dport_resp_valid, i_dport_resp_error;
    logic [W-1:0]  i_dport_rdata;
    logic          o_dport_resp_ready, o_owner, o_busy, o_timeout;

    int unsigned errors = 0;
    int unsigned checks = 0;

    dport_arbiter #(.RISCV_ARCH(W), .TYPE_W(TW), .TIMEOUT(8), .CNT_W(16)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_m0_req_valid(i_m0_req_valid), .i_m0_type(i_m0_type), .i_m0_addr(i_m0_addr),
        .i_m0_wdata(i_m0_wdata), .i_m0_size(i_m0_size), .o_m0_req_ready(o_m0_req_ready),
        .i_m0_resp_ready(i_m0_resp_ready), .o_m0_resp_valid(o_m0_resp_valid),
        .o_m0_resp_error(o_m0_resp_error), .o_m0_rdata(o_m0_rdata),
        .i_m1_req_valid(i_m1_req_valid), .i_m1_type(i_m1_type), .i_m1_addr(i_m1_addr),
        .i_m1_wdata(i_m1_wdata), .i_m1_size(i_m1_size), .o_m1_req_ready(o_m1_req_ready),
        .i_m1_resp_ready(i_m1_resp_ready), .o_m1_resp_valid(o_m1_resp_valid),
        .o_m1_resp_error(o_m1_resp_error), .o_m1_rdata(o_m1_rdata),
        .o_dport_req_valid(o_dport_req_valid), .o_dport_type(o_dport_type),
        .o_dport_addr(o_dport_addr), .o_dport_wdata(o_dport_wdata), .o_dport_size(o_dport_size),
        .i_dport_req_ready(i_dport_req_ready), .i_dport_resp_valid(i_dport_resp_valid),
        .i_dport_resp_error(i_dport_resp_error), .i_dport_rdata(i_dport_rdata),
        .o_dport_resp_ready(o_dport_resp_ready), .o_owner(o_owner), .o_busy(o_busy),
        .o_timeout(o_timeout)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns 2 time units after the next rising edge; inputs change there.
    task automatic cyc();
        @(posedge i_clk);
        #2;
    endtask

    // Full transaction entered in an IDLE cycle with requests already driven.
    task automatic do_txn(input logic exp, input logic [W-1:0] data);
        #1;
        chk("txn_win_ready", exp ? o_m1_req_ready : o_m0_req_ready, 1);
        chk("txn_lose_ready", exp ? o_m0_req_ready : o_m1_req_ready, 0);
        cyc();
        i_dport_req_ready = 1'b1;
        #1;
        chk("txn_owner", o_owner, exp);
        cyc();
        i_dport_req_ready  = 1'b0;
        i_dport_resp_valid = 1'b1;
        i_dport_rdata      = data;
        i_m0_resp_ready    = 1'b1;
        i_m1_resp_ready    = 1'b1;
        #1;
        chk("txn_owner_resp_valid", exp ? o_m1_resp_valid : o_m0_resp_valid, 1);
        chk("txn_other_resp_valid", exp ? o_m0_resp_valid : o_m1_resp_valid, 0);
        chk("txn_rdata", exp ? o_m1_rdata : o_m0_rdata, data);
        chk("txn_resp_owner", o_owner, exp);
        cyc();
        i_dport_resp_valid = 1'b0;
    endtask

    initial begin
        i_rst = 1'b1;
        i_m0_req_valid = 1'b1; i_m0_type = 5'd1; i_m0_addr = 64'h1005;
        i_m0_wdata = '0; i_m0_size = 3'd2; i_m0_resp_ready = 1'b0;
        i_m1_req_valid = 1'b0; i_m1_type = 5'd3; i_m1_addr = 64'h2008;
        i_m1_wdata = 64'hBEEF; i_m1_size = 3'd3; i_m1_resp_ready = 1'b0;
        i_dport_req_ready = 1'b0; i_dport_resp_valid = 1'b0;
        i_dport_resp_error = 1'b0; i_dport_rdata = '0;

        // Reset state, outputs forced low even with a pending request
        cyc(); cyc(); #1;
        chk("rst_m0_req_ready", o_m0_req_ready, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_owner", o_owner, 0);
        chk("rst_dport_req_valid", o_dport_req_valid, 0);
        chk("rst_dport_addr", o_dport_addr, 0);
        chk("rst_timeout", o_timeout, 0);

        // Single read from m0
        i_rst = 1'b0; #1;
        chk("rd_m0_ready_T0", o_m0_req_ready, 1);
        chk("rd_m1_ready_T0", o_m1_req_ready, 0);
        chk("rd_req_valid_T0", o_dport_req_valid, 0);
        cyc(); i_m0_req_valid = 1'b0; #1;
        chk("rd_req_valid_T1", o_dport_req_valid, 1);
        chk("rd_addr", o_dport_addr, 64'h1005);
        chk("rd_type", o_dport_type, 1);
        chk("rd_size", o_dport_size, 2);
        chk("rd_m0_ready_T1", o_m0_req_ready, 0);
        chk("rd_busy", o_busy, 1);
        cyc(); #1;
        chk("rd_req_valid_T2", o_dport_req_valid, 1);
        cyc(); i_dport_req_ready = 1'b1; #1;
        chk("rd_req_valid_T3", o_dport_req_valid, 1);
        cyc(); i_dport_req_ready = 1'b0; #1;
        chk("rd_req_valid_T4", o_dport_req_valid, 0);
        chk("rd_resp_valid_T4", o_m0_resp_valid, 0);
        cyc();
        cyc(); i_dport_resp_valid = 1'b1; i_dport_rdata = 64'h1234; i_m0_resp_ready = 1'b1; #1;
        chk("rd_m0_resp_valid", o_m0_resp_valid, 1);
        chk("rd_m0_rdata", o_m0_rdata, 64'h1234);
        chk("rd_m0_error", o_m0_resp_error, 0);
        chk("rd_m1_resp_valid", o_m1_resp_valid, 0);
        chk("rd_m1_rdata", o_m1_rdata, 0);
        chk("rd_dport_resp_ready", o_dport_resp_ready, 1);
        cyc(); i_dport_resp_valid = 1'b0; i_m0_resp_ready = 1'b0; #1;
        chk("rd_idle", o_busy, 0);

        // Contention after reset
        i_rst = 1'b1; cyc(); i_rst = 1'b0;
        i_m0_req_valid = 1'b1; i_m1_req_valid = 1'b1;
        do_txn(1'b0, 64'hA0);
        do_txn(1'b1, 64'hA1);
        do_txn(1'b0, 64'hA2);
        do_txn(1'b1, 64'hA3);
        i_m0_req_valid = 1'b0; i_m0_resp_ready = 1'b0; i_m1_resp_ready = 1'b0;

        // m1 response backpressure
        #1;
        chk("bp_m1_ready", o_m1_req_ready, 1);
        cyc(); i_m1_req_valid = 1'b0; i_dport_req_ready = 1'b1;
        cyc(); i_dport_req_ready = 1'b0; i_dport_resp_valid = 1'b1; i_dport_rdata = 64'hABCD;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_dport_resp_ready", o_dport_resp_ready, 0);
            chk("bp_m1_resp_valid", o_m1_resp_valid, 1);
            chk("bp_m1_rdata", o_m1_rdata, 64'hABCD);
            cyc();
        end
        i_m1_resp_ready = 1'b1; #1;
        chk("bp_hs_ready", o_dport_resp_ready, 1);
        chk("bp_hs_valid", o_m1_resp_valid, 1);
        cyc(); i_dport_resp_valid = 1'b0; i_m1_resp_ready = 1'b0; #1;
        chk("bp_idle", o_busy, 0);
        chk("bp_no_resp", o_m1_resp_valid, 0);

        // Request-phase timeout on m0
        i_m0_req_valid = 1'b1; i_m0_addr = 64'h2000; #1;
        chk("rto_m0_ready", o_m0_req_ready, 1);
        cyc(); i_m0_req_valid = 1'b0;
        for (int i = 1; i < 8; i++) begin
            #1;
            chk("rto_no_timeout", o_timeout, 0);
            chk("rto_req_valid", o_dport_req_valid, 1);
            cyc();
        end
        #1;
        chk("rto_timeout", o_timeout, 1);
        chk("rto_no_resp_yet", o_m0_resp_valid, 0);
        cyc(); #1;
        chk("rto_req_dropped", o_dport_req_valid, 0);
        chk("rto_m0_resp_valid", o_m0_resp_valid, 1);
        chk("rto_m0_error", o_m0_resp_error, 1);
        chk("rto_m0_rdata", o_m0_rdata, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("rto_no_drain", o_dport_resp_ready, 0);
        chk("rto_m1_resp_valid", o_m1_resp_valid, 0);
        chk("rto_pulse_end", o_timeout, 0);
        i_m0_resp_ready = 1'b1;
        cyc(); i_m0_resp_ready = 1'b0; #1;
        chk("rto_idle", o_busy, 0);
        chk("rto_req_valid_after", o_dport_req_valid, 0);

        // Response-phase timeout on m1 with a late response drained
        i_m1_req_valid = 1'b1; #1;
        chk("pto_m1_ready", o_m1_req_ready, 1);
        cyc(); i_m1_req_valid = 1'b0; i_dport_req_ready = 1'b1;
        cyc(); i_dport_req_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("pto_no_timeout", o_timeout, 0);
            chk("pto_no_resp", o_m1_resp_valid, 0);
            cyc();
        end
        #1;
        chk("pto_timeout", o_timeout, 1);
        cyc(); #1;
        chk("pto_m1_resp_valid", o_m1_resp_valid, 1);
        chk("pto_m1_error", o_m1_resp_error, 1);
        chk("pto_drain_ready", o_dport_resp_ready, 1);
        i_m1_resp_ready = 1'b1;
        cyc(); i_m1_resp_ready = 1'b0; i_m0_req_valid = 1'b1; i_m1_req_valid = 1'b1;
        for (int i = 0; i < 11; i++) begin
            #1;
            chk("drain_no_m0_grant", o_m0_req_ready, 0);
            chk("drain_no_m1_grant", o_m1_req_ready, 0);
            chk("drain_busy", o_busy, 1);
            chk("drain_resp_ready", o_dport_resp_ready, 1);
            cyc();
        end
        i_dport_resp_valid = 1'b1; i_dport_rdata = 64'h55; #1;
        chk("drain_m0_resp_valid", o_m0_resp_valid, 0);
        chk("drain_m1_resp_valid", o_m1_resp_valid, 0);
        chk("drain_consume", o_dport_resp_ready, 1);
        cyc(); i_dport_resp_valid = 1'b0; #1;
        chk("drain_next_m0", o_m0_req_ready, 1);
        chk("drain_next_m1", o_m1_req_ready, 0);

        // Reset in the middle of an m1 response
        do_txn(1'b0, 64'hC0);
        #1;
        chk("mrst_m1_ready", o_m1_req_ready, 1);
        cyc(); i_dport_req_ready = 1'b1;
        cyc(); i_dport_req_ready = 1'b0; i_dport_resp_valid = 1'b1;
        i_m0_resp_ready = 1'b0; i_m1_resp_ready = 1'b0; #1;
        chk("mrst_m1_resp_valid", o_m1_resp_valid, 1);
        i_rst = 1'b1; #1;
        chk("mrst_resp_valid_low", o_m1_resp_valid, 0);
        chk("mrst_resp_ready_low", o_dport_resp_ready, 0);
        chk("mrst_busy_low", o_busy, 0);
        chk("mrst_owner_low", o_owner, 0);
        chk("mrst_m0_ready_low", o_m0_req_ready, 0);
        cyc(); i_rst = 1'b0; i_dport_resp_valid = 1'b0; #1;
        chk("mrst_idle", o_busy, 0);
        chk("mrst_owner", o_owner, 0);
        chk("mrst_req_valid", o_dport_req_valid, 0);
        chk("mrst_m0_wins", o_m0_req_ready, 1);
        chk("mrst_m1_loses", o_m1_req_ready, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dport_arbiter.md
Name: dport_arbiter

Overview:
- Two-requester round-robin arbiter that shares one core debug-port request/response channel.
- Requester 0 is the DMI/abstract-command path; requester 1 is a secondary debugger, e.g. a UART debug bridge.
- Exactly one transaction is outstanding on the shared channel at any time. The grant is held from request through response, and the response is routed back only to the owner.
- A watchdog returns an error response if the debug port stalls, then discards the late response when it arrives.

Parameters:
- RISCV_ARCH, 64, data/address width.
- TYPE_W, 5, width of the request type vector (DPortReq_Total).
- TIMEOUT, 4096, watchdog limit in cycles; 0 disables the watchdog.
- CNT_W, 16, watchdog counter width; TIMEOUT must be < 2^CNT_W.

Ports:
- i_clk in 1: clock.
- i_rst in 1: reset, synchronous, active-high.
- i_mN_req_valid in 1 (N=0,1): request valid.
- i_mN_type in TYPE_W: request type.
- i_mN_addr in RISCV_ARCH: request address.
- i_mN_wdata in RISCV_ARCH: write data.
- i_mN_size in 3: access size.
- o_mN_req_ready out 1: request accepted (grant pulse).
- i_mN_resp_ready in 1: requester accepts response.
- o_mN_resp_valid out 1: response valid.
- o_mN_resp_error out 1: response error.
- o_mN_rdata out RISCV_ARCH: response data.
- o_dport_req_valid out 1: request valid to debug port.
- o_dport_type out TYPE_W: latched request type.
- o_dport_addr out RISCV_ARCH: latched address.
- o_dport_wdata out RISCV_ARCH: latched write data.
- o_dport_size out 3: latched size.
- i_dport_req_ready in 1: debug port accepted request.
- i_dport_resp_valid in 1: debug port response valid.
- i_dport_resp_error in 1: debug port response error.
- i_dport_rdata in RISCV_ARCH: debug port response data.
- o_dport_resp_ready out 1: arbiter accepts debug port response.
- o_owner out 1: current or last granted requester.
- o_busy out 1: state != IDLE.
- o_timeout out 1: one-cycle pulse when the watchdog fires.

Behaviour:
- Reset state: IDLE, priority pointer=0, owner=0, drain flag=0, counter=0, latched request fields=0.
- Reset values: every o_* output is 0 while i_rst=1. This includes o_mN_req_ready, whose IDLE default is otherwise 1 only for the winner.
- Reset mid-transaction: return to IDLE at once; any in-flight debug port response is lost. The debug port must be reset together with this block.

IDLE:
- If exactly one i_mN_req_valid=1, grant it.
- If both are valid, grant the requester the pointer selects.
- On grant: o_mN_req_ready=1 combinationally for the winner only; latch type/addr/wdata/size; owner=N; counter=0; next state REQ.
- With no valid request, no ready is asserted.

REQ:
- o_dport_req_valid=1 with the latched fields, stable.
- First dport_req_valid occurs one cycle after the grant.
- i_dport_req_ready=1 -> RESP.

RESP:
- o_mOwner_resp_valid = i_dport_resp_valid.
- error and rdata pass through combinationally.
- o_dport_resp_ready = i_mOwner_resp_ready.
- The non-owner sees resp_valid=0.
- On handshake (valid & ready): pointer = ~owner, next state IDLE. The last owner gets lowest priority.

Watchdog:
- Counter increments every cycle in REQ and RESP.
- It fires when counter == TIMEOUT-1 and the state's completion event does not occur that cycle. Completion wins a same-cycle tie.
- Fire in REQ: drop o_dport_req_valid; drain=0; next state TOUT_RESP.
- Fire in RESP: drain=1; next state TOUT_RESP.
- o_timeout pulses on the firing cycle.

TOUT_RESP:
- Owner sees resp_valid=1, error=1, rdata = all ones.
- o_dport_resp_ready = drain. A debug port response arriving here is consumed and clears drain.
- On owner resp_ready: if drain is still 1 after this cycle -> DRAIN, else IDLE. Pointer = ~owner in both cases.

DRAIN:
- o_dport_resp_ready=1; no grants are issued.
- i_dport_resp_valid -> drain=0, next state IDLE.
- No timeout in DRAIN.

General rules:
- Non-owner o_mN_req_ready=0 in all states except IDLE.
- Requesters may hold valid across any number of cycles.
- The counter saturates and never wraps.
- TIMEOUT=0: the counter is inert and o_timeout is never asserted.

Test Plan:
- Single read: m0 type=RegAccess, addr=0x1005. Debug port: req_ready after 2 cycles, resp rdata=0x1234 after 3 more cycles. Expected: m0 req_ready at T0; dport_req_valid T1–T3; m0 gets resp_valid with rdata=0x1234, error=0; m1 outputs stay 0.
- Contention after reset: both requesters valid continuously for 4 transactions. Expected grant order m0, m1, m0, m1; o_owner matches each response.
- Response backpressure: m1 resp_ready low for 5 cycles while dport_resp_valid=1. Expected: o_dport_resp_ready=0 for those 5 cycles; rdata held; single handshake; then IDLE.
- Request-phase timeout, TIMEOUT=8: dport_req_ready held 0. Expected: o_timeout at cycle 8 after the grant; owner gets error=1, rdata=0xFFFF_FFFF_FFFF_FFFF; next state IDLE; dport_req_valid=0 afterwards.
- Response-phase timeout, TIMEOUT=8: request accepted, debug port response arrives 20 cycles later. Expected: error response to owner; DRAIN consumes the late response; no resp_valid on either requester; the next grant goes to the other requester.
- Reset mid-RESP: i_rst=1 for 1 cycle. Expected: all outputs 0 next cycle; o_busy=0; pointer=0, so m0 wins the next contention.
